// File: rtl/uart_tx_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit engine.
//                Frame format matches the RX path (1 start, 8 data LSB
//                first, optional even parity, 1 stop).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int   UART_DATA_W = 8;
   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_BIT   = 1'b0;
   localparam logic STOP_BIT    = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Even parity bit: makes the total count of ones (data + parity) even.
   function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
      return ^data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine_if
//  Description : Host-side handshake and serial line of the UART TX engine.
//  Signals     : tx_data[7:0]  byte to transmit (host -> engine)
//                data_write    one-cycle write strobe (host -> engine)
//                clear_error   one-cycle overrun clear (host -> engine)
//                tx_ready      holding buffer empty (engine -> host)
//                tx_busy       frame in progress (engine -> host)
//                overrun_error sticky dropped-write flag (engine -> host)
//                serial_out    serial line, idle high (engine -> line)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_engine_if;
   import uart_pkg::*;

   logic [UART_DATA_W-1:0] tx_data;
   logic                   data_write;
   logic                   clear_error;
   logic                   tx_ready;
   logic                   tx_busy;
   logic                   overrun_error;
   logic                   serial_out;

   modport master (
      output tx_data, data_write, clear_error,
      input  tx_ready, tx_busy, overrun_error, serial_out
   );

   modport slave (
      input  tx_data, data_write, clear_error,
      output tx_ready, tx_busy, overrun_error, serial_out
   );

endinterface
`default_nettype wire

// File: rtl/uart_tx_engine_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tx_bit_timer
//  Description : Bit-period timer. Counts 0..BIT_PERIOD-1 while enabled and
//                flags the terminal count, then wraps so consecutive bits
//                stay exactly BIT_PERIOD clocks long.
//  Ports       : clk       system clock
//                rst       synchronous active-high reset
//                enable    count this cycle
//                clear     force the count back to zero
//                bit_done  terminal count reached while enabled
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_bit_timer #(
   parameter int BIT_PERIOD = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic bit_done
);

   localparam int                 c_CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIT_PERIOD - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   logic [c_CNT_W-1:0] r_cnt;
   logic               w_term;

   assign w_term   = (r_cnt == c_LAST);
   assign bit_done = enable && w_term;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= w_term ? '0 : r_cnt + c_ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine
//  Description : UART transmitter with a one-entry holding buffer. Sends
//                start, 8 data bits LSB first, optional even parity, stop.
//                Back-to-back frames leave no idle gap.
//  Ports       : clk   system clock (rising edge)
//                rst   synchronous active-high reset
//                bus   uart_tx_engine_if.slave (host handshake + serial_out)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int BIT_PERIOD = 10,
   parameter bit PARITY_EN  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_engine_if.slave  bus
);

   tx_state_t              r_state;
   tx_state_t              w_state_nxt;
   logic [UART_DATA_W-1:0] r_hold_data;
   logic                   r_hold_valid;
   logic [UART_DATA_W-1:0] r_shift;
   logic                   r_parity;
   logic [2:0]             r_bit_idx;
   logic                   r_overrun;
   logic                   r_serial;
   logic                   w_serial_nxt;
   logic                   w_bit_done;
   logic                   w_consume;
   logic                   w_shift;
   logic                   w_accept;
   logic                   w_drop;

   // Timer runs in every active state; holding it clear in IDLE restarts
   // it at zero on each frame entry from idle.
   tx_bit_timer #(
      .BIT_PERIOD (BIT_PERIOD)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .enable   (r_state != IDLE),
      .clear    (r_state == IDLE),
      .bit_done (w_bit_done)
   );

   // A write into a full buffer still succeeds if the FSM takes the
   // buffered byte on the same edge.
   assign w_accept = bus.data_write && (!r_hold_valid || w_consume);
   assign w_drop   = bus.data_write &&   r_hold_valid && !w_consume;

   assign bus.tx_ready      = ~r_hold_valid;
   assign bus.tx_busy       = (r_state != IDLE);
   assign bus.overrun_error = r_overrun;
   assign bus.serial_out    = r_serial;

   // ---- State register ----------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---- Next-state logic --------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (r_hold_valid) w_state_nxt = START;
         START:   if (w_bit_done)   w_state_nxt = DATA;
         DATA:    if (w_bit_done && (r_bit_idx == 3'd7))
                     w_state_nxt = PARITY_EN ? PARITY : STOP;
         PARITY:  if (w_bit_done)   w_state_nxt = STOP;
         STOP:    if (w_bit_done)   w_state_nxt = r_hold_valid ? START : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---- Output logic: next line level and datapath strobes ----------------
   // The line level is chosen one cycle ahead and registered so that each
   // bit starts exactly on the edge that enters it.
   always_comb begin
      w_serial_nxt = r_serial;
      w_consume    = 1'b0;
      w_shift      = 1'b0;
      case (r_state)
         IDLE: begin
            w_serial_nxt = LINE_IDLE;
            if (r_hold_valid) begin
               w_consume    = 1'b1;
               w_serial_nxt = START_BIT;
            end
         end
         START: begin
            if (w_bit_done) w_serial_nxt = r_shift[0];
         end
         DATA: begin
            if (w_bit_done) begin
               w_shift = 1'b1;
               if (r_bit_idx == 3'd7) begin
                  w_serial_nxt = PARITY_EN ? r_parity : STOP_BIT;
               end else begin
                  // Bit that becomes shifter[0] after this shift.
                  w_serial_nxt = r_shift[1];
               end
            end
         end
         PARITY: begin
            if (w_bit_done) w_serial_nxt = STOP_BIT;
         end
         STOP: begin
            if (w_bit_done) begin
               if (r_hold_valid) begin
                  w_consume    = 1'b1;
                  w_serial_nxt = START_BIT;
               end else begin
                  w_serial_nxt = LINE_IDLE;
               end
            end
         end
         default: w_serial_nxt = LINE_IDLE;
      endcase
   end

   // ---- Datapath: holding buffer, shifter, error flag, line register ------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_data  <= 8'hFF;
         r_hold_valid <= 1'b0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_bit_idx    <= 3'd0;
         r_overrun    <= 1'b0;
         r_serial     <= LINE_IDLE;
      end else begin
         r_serial <= w_serial_nxt;

         if (w_accept) begin
            r_hold_data  <= bus.tx_data;
            r_hold_valid <= 1'b1;
         end else if (w_consume) begin
            r_hold_valid <= 1'b0;
         end

         // A new overrun outranks a simultaneous clear.
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (bus.clear_error) begin
            r_overrun <= 1'b0;
         end

         if (w_consume) begin
            r_shift   <= r_hold_data;
            r_parity  <= even_parity(r_hold_data);
            r_bit_idx <= 3'd0;
         end else if (w_shift) begin
            r_shift   <= {1'b0, r_shift[UART_DATA_W-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_engine
//  Description : Self-checking bench for uart_tx_engine. Three builds are
//                instantiated: (10,parity), (10,no parity), (2,parity).
//                Written bytes go to a scoreboard queue; a frame checker
//                pops them and compares the line cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_engine_if if0 ();
   uart_tx_engine_if if1 ();
   uart_tx_engine_if if2 ();

   uart_tx_engine #(.BIT_PERIOD(10), .PARITY_EN(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   uart_tx_engine #(.BIT_PERIOD(10), .PARITY_EN(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   uart_tx_engine #(.BIT_PERIOD(2),  .PARITY_EN(1'b1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   typedef struct {
      logic [7:0] data;
      logic       par;
   } sb_t;

   typedef struct {
      int         inst;
      int         bp;
      bit         pen;
      logic [7:0] data;
      logic       par;
   } vec_t;

   sb_t  sb[$];
   vec_t vecs[7];
   int   checks = 0;
   int   errors = 0;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic ser(input int i);
      case (i)
         0:       return if0.serial_out;
         1:       return if1.serial_out;
         default: return if2.serial_out;
      endcase
   endfunction

   function automatic logic busy(input int i);
      case (i)
         0:       return if0.tx_busy;
         1:       return if1.tx_busy;
         default: return if2.tx_busy;
      endcase
   endfunction

   function automatic logic ready(input int i);
      case (i)
         0:       return if0.tx_ready;
         1:       return if1.tx_ready;
         default: return if2.tx_ready;
      endcase
   endfunction

   function automatic logic ovr(input int i);
      case (i)
         0:       return if0.overrun_error;
         1:       return if1.overrun_error;
         default: return if2.overrun_error;
      endcase
   endfunction

   task automatic drive(input int i, input logic dw, input logic [7:0] d, input logic clr);
      case (i)
         0:       begin if0.data_write = dw; if0.tx_data = d; if0.clear_error = clr; end
         1:       begin if1.data_write = dw; if1.tx_data = d; if1.clear_error = clr; end
         default: begin if2.data_write = dw; if2.tx_data = d; if2.clear_error = clr; end
      endcase
   endtask

   // One-cycle write strobe; returns just after the edge that samples it.
   task automatic write_byte(input int i, input logic [7:0] d, input logic clr,
                             input bit push, input logic par);
      sb_t e;
      @(posedge clk); #1;
      drive(i, 1'b1, d, clr);
      if (push) begin
         e.data = d;
         e.par  = par;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      drive(i, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic pulse_clear(input int i);
      @(posedge clk); #1;
      drive(i, 1'b0, 8'h00, 1'b1);
      @(posedge clk); #1;
      drive(i, 1'b0, 8'h00, 1'b0);
   endtask

   // Pops the next expected byte, waits (bounded) for the start bit, then
   // requires every bit to hold its level for exactly bp clocks with
   // tx_busy high throughout.
   task automatic check_frame(input int i, input int bp, input bit pen, input int max_wait,
                              input string tag, output int lat);
      sb_t         e;
      int          w;
      int          nb;
      bit          ok;
      logic [10:0] bits;
      check_eq({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) e = sb.pop_front();
      else begin e.data = 8'h00; e.par = 1'b0; end
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (ser(i) !== 1'b0 && w < max_wait);
      lat = w;
      check_eq({tag, " start_seen"}, ser(i), 1'b0);
      nb      = pen ? 11 : 10;
      bits    = '1;
      bits[0] = 1'b0;
      for (int j = 0; j < 8; j++) bits[j+1] = e.data[j];
      if (pen) bits[9] = e.par;
      for (int j = 0; j < nb; j++) begin
         ok = 1'b1;
         for (int k = 0; k < bp; k++) begin
            if (j != 0 || k != 0) @(negedge clk);
            if (ser(i) !== bits[j] || busy(i) !== 1'b1) ok = 1'b0;
         end
         check_eq($sformatf("%s bit%0d", tag, j), 32'(ok), 32'd1);
      end
   endtask

   task automatic check_idle(input int i, input string tag);
      @(negedge clk);
      check_eq({tag, " idle_line"},  ser(i),   1'b1);
      check_eq({tag, " idle_busy"},  busy(i),  1'b0);
      check_eq({tag, " idle_ready"}, ready(i), 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int w;

      vecs[0] = '{0, 10, 1'b1, 8'hA5, 1'b0};
      vecs[1] = '{0, 10, 1'b1, 8'h01, 1'b1};
      vecs[2] = '{1, 10, 1'b0, 8'h01, 1'b0};
      vecs[3] = '{2,  2, 1'b1, 8'h80, 1'b1};
      vecs[4] = '{1, 10, 1'b0, 8'hA5, 1'b0};
      vecs[5] = '{2,  2, 1'b1, 8'h5A, 1'b0};
      vecs[6] = '{0, 10, 1'b1, 8'h7E, 1'b0};

      for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state of every build
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("reset%0d line",  i), ser(i),   1'b1);
         check_eq($sformatf("reset%0d ready", i), ready(i), 1'b1);
         check_eq($sformatf("reset%0d busy",  i), busy(i),  1'b0);
         check_eq($sformatf("reset%0d ovr",   i), ovr(i),   1'b0);
      end

      // Single frames from idle: latency, bit timing, parity, frame length
      for (int v = 0; v < 7; v++) begin
         write_byte(vecs[v].inst, vecs[v].data, 1'b0, 1'b1, vecs[v].par);
         check_frame(vecs[v].inst, vecs[v].bp, vecs[v].pen, 4, $sformatf("vec%0d", v), lat);
         check_eq($sformatf("vec%0d latency", v), 32'(lat), 32'd2);
         check_idle(vecs[v].inst, $sformatf("vec%0d", v));
      end

      // Back-to-back: second byte buffered mid-frame, no idle gap
      write_byte(0, 8'h3C, 1'b0, 1'b1, 1'b0);
      fork
         check_frame(0, 10, 1'b1, 4, "b2b_first", lat);
         begin
            repeat (30) @(posedge clk);
            write_byte(0, 8'hC3, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check_eq("b2b ready_low", ready(0), 1'b0);
         end
      join
      check_frame(0, 10, 1'b1, 1, "b2b_second", lat);
      check_eq("b2b no_gap", 32'(lat), 32'd1);
      check_eq("b2b ovr", ovr(0), 1'b0);
      check_idle(0, "b2b");

      // Overrun: third write dropped, clear, clear racing a new overrun
      write_byte(0, 8'h11, 1'b0, 1'b1, 1'b0);
      fork
         check_frame(0, 10, 1'b1, 4, "ovr_first", lat);
         begin
            repeat (30) @(posedge clk);
            write_byte(0, 8'h22, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check_eq("ovr before", ovr(0), 1'b0);
            write_byte(0, 8'h33, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check_eq("ovr set", ovr(0), 1'b1);
            pulse_clear(0);
            @(negedge clk);
            check_eq("ovr cleared", ovr(0), 1'b0);
            write_byte(0, 8'h44, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            check_eq("ovr beats clear", ovr(0), 1'b1);
            pulse_clear(0);
         end
      join
      check_frame(0, 10, 1'b1, 1, "ovr_second", lat);
      check_eq("ovr second no_gap", 32'(lat), 32'd1);
      check_idle(0, "ovr");

      // Reset during data bit 4 of 0xFF aborts the frame
      write_byte(0, 8'hFF, 1'b0, 1'b0, 1'b0);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (ser(0) !== 1'b0 && w < 4);
      check_eq("abort start_seen", ser(0), 1'b0);
      repeat (54) @(negedge clk);
      check_eq("abort in bit4", ser(0), 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      check_eq("abort line",  ser(0),   1'b1);
      check_eq("abort busy",  busy(0),  1'b0);
      check_eq("abort ready", ready(0), 1'b1);
      rst = 1'b0;
      write_byte(0, 8'h5A, 1'b0, 1'b1, 1'b0);
      check_frame(0, 10, 1'b1, 4, "after_abort", lat);
      check_eq("after_abort latency", 32'(lat), 32'd2);
      check_idle(0, "after_abort");

      check_eq("sb drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
